// File: rtl/reveal_flood_pkg.sv
// reveal_flood_pkg: board geometry, FSM state encoding and the neighbour offset table.
package reveal_flood_pkg;
  localparam int boardWidth = 8;
  localparam int boardHeight = 8;
  localparam int coordW = 3;
  localparam int cellCount = boardWidth * boardHeight;
  typedef enum logic [2:0] {INIT, FIRST, POP, SCAN, DONE, LOST} stateT;
  // Neighbour order NW,N,NE,W,E,SW,S,SE.
  function automatic logic signed [3:0] offX(input logic [2:0] k);
    return (k == 3'd0 || k == 3'd3 || k == 3'd5) ? -4'sd1 :
           (k == 3'd2 || k == 3'd4 || k == 3'd7) ? 4'sd1 : 4'sd0;
  endfunction
  function automatic logic signed [3:0] offY(input logic [2:0] k);
    return (k < 3'd3) ? -4'sd1 : (k > 3'd4) ? 4'sd1 : 4'sd0;
  endfunction
endpackage

// File: rtl/reveal_flood_if.sv
// reveal_flood_if: shared board read port plus the revealed-board write strobe.
interface reveal_flood_if;
  import reveal_flood_pkg::*;
  logic [coordW-1:0] readX, readY;
  logic revWriteEn;
  logic mineReadValue, revReadValue;
  logic [3:0] adjReadValue;
  modport master(output readX, readY, revWriteEn, input mineReadValue, adjReadValue, revReadValue);
  modport slave(input readX, readY, revWriteEn, output mineReadValue, adjReadValue, revReadValue);
endinterface

// File: rtl/reveal_flood_lifo_stack.sv
// lifo_stack: synchronous LIFO of packed {x,y} cells; pointer cleared by reset.
module lifo_stack #(
  parameter int depth = 64,
  parameter int width = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [width-1:0] data,
  output logic [width-1:0] top,
  output logic empty
);
  localparam int aw = $clog2(depth);
  logic [width-1:0] mem [depth];
  logic [aw:0] sp;
  logic [aw-1:0] topIdx;
  assign topIdx = aw'(sp - 1'b1);
  assign top = mem[topIdx];
  assign empty = sp == '0;
  always_ff @(posedge clk) begin
    if (reset) sp <= '0;
    else if (push) begin
      mem[sp[aw-1:0]] <= data;
      sp <= sp + 1'b1;
    end else if (pop) sp <= sp - 1'b1;
  end
endmodule

// File: rtl/reveal_flood.sv
// reveal_flood: reveals the chosen cell, reports a mine hit, and flood-fills zero-adjacency regions.
module reveal_flood
  import reveal_flood_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic ack,
  input  logic [coordW-1:0] startX,
  input  logic [coordW-1:0] startY,
  reveal_flood_if.master board,
  output logic [6:0] revealedCount,
  output logic hitMine,
  output logic init,
  output logic first,
  output logic pop,
  output logic scan,
  output logic done,
  output logic lost
);
  stateT state;
  logic [coordW-1:0] sx, sy, cx, cy, holdX, holdY;
  logic [2:0] nbr;
  logic signed [3:0] nx, ny;
  logic inb, reveal, push, popEn, empty;
  logic [2*coordW-1:0] topCell;
  assign init = state == INIT;
  assign first = state == FIRST;
  assign pop = state == POP;
  assign scan = state == SCAN;
  assign done = state == DONE;
  assign lost = state == LOST;
  always_comb begin
    nx = $signed({1'b0, cx}) + offX(nbr);
    ny = $signed({1'b0, cy}) + offY(nbr);
    // On a power-of-two board, coordinate 8 wraps to -8, so the sign bit flags both edges.
    inb = !nx[3] && !ny[3];
    board.readX = first ? sx : (scan && inb) ? nx[coordW-1:0] : holdX;
    board.readY = first ? sy : (scan && inb) ? ny[coordW-1:0] : holdY;
    reveal = !reset && !board.revReadValue && !board.mineReadValue && (first || (scan && inb));
    board.revWriteEn = reveal;
    push = reveal && board.adjReadValue == 4'd0;
    popEn = pop && !empty;
  end
  lifo_stack #(.depth(cellCount), .width(2 * coordW)) stack (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(popEn),
    .data({board.readX, board.readY}),
    .top(topCell),
    .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      revealedCount <= '0;
      hitMine <= 1'b0;
      holdX <= '0;
      holdY <= '0;
    end else begin
      holdX <= board.readX;
      holdY <= board.readY;
      if (reveal) revealedCount <= revealedCount + 1'b1;
      unique case (state)
        INIT: if (start) begin
          sx <= startX;
          sy <= startY;
          revealedCount <= '0;
          hitMine <= 1'b0;
          state <= FIRST;
        end
        FIRST: begin
          hitMine <= board.mineReadValue;
          state <= board.mineReadValue ? LOST : board.revReadValue ? DONE : push ? POP : DONE;
        end
        POP: begin
          {cx, cy} <= topCell;
          nbr <= 3'd0;
          state <= empty ? DONE : SCAN;
        end
        SCAN: begin
          nbr <= nbr + 1'b1;
          if (nbr == 3'd7) state <= POP;
        end
        DONE, LOST: if (ack) state <= INIT;
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_reveal_flood.sv
// tb_reveal_flood: directed scenarios on a modelled 8x8 board with hand-computed expectations.
module tb_reveal_flood;
  import reveal_flood_pkg::*;
  logic clk_tb = 1'b0;
  logic reset, start, ack, clearRev;
  logic [2:0] startX, startY;
  logic [6:0] revealedCount;
  logic hitMine, init, first, pop, scan, done, lost;
  logic mine [64];
  logic rev [64];
  logic [3:0] adj [64];
  int writes, lastWrite, cycles, w0;
  int checks = 0;
  int failures = 0;
  reveal_flood_if board();
  reveal_flood dut (
    .clk(clk_tb), .reset(reset), .start(start), .ack(ack),
    .startX(startX), .startY(startY), .board(board),
    .revealedCount(revealedCount), .hitMine(hitMine),
    .init(init), .first(first), .pop(pop), .scan(scan), .done(done), .lost(lost)
  );
  always #5 clk_tb = ~clk_tb;
  assign board.mineReadValue = mine[{board.readY, board.readX}];
  assign board.adjReadValue = adj[{board.readY, board.readX}];
  assign board.revReadValue = rev[{board.readY, board.readX}];
  always @(posedge clk_tb) begin
    if (clearRev) begin
      for (int i = 0; i < 64; i++) rev[i] <= 1'b0;
      writes <= 0;
    end else if (board.revWriteEn) begin
      rev[{board.readY, board.readX}] <= 1'b1;
      writes <= writes + 1;
      lastWrite <= int'({board.readY, board.readX});
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic setMines(input int kind);
    int x, y, n;
    for (int i = 0; i < 64; i++) begin
      x = i % 8;
      y = i / 8;
      mine[i] = kind == 1 ? (x == 2 && y == 2) : kind == 2 ? (x == 0 && y == 0) : kind == 3 ? (x == 4) : 1'b0;
    end
    for (int i = 0; i < 64; i++) begin
      x = i % 8;
      y = i / 8;
      n = 0;
      for (int dy = -1; dy <= 1; dy++)
        for (int dx = -1; dx <= 1; dx++)
          if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < 8 && y + dy >= 0 && y + dy < 8)
            if (mine[(y + dy) * 8 + x + dx]) n++;
      adj[i] = 4'(n);
    end
  endtask
  task automatic clearBoard();
    clearRev = 1'b1;
    @(posedge clk_tb);
    #1 clearRev = 1'b0;
  endtask
  task automatic runOp(input logic [2:0] x, input logic [2:0] y, output int cyc);
    startX = x;
    startY = y;
    start = 1'b1;
    @(posedge clk_tb);
    #1 start = 1'b0;
    cyc = 1;
    while (!(done || lost) && cyc < 1000) begin
      @(posedge clk_tb);
      #1 cyc++;
    end
    chk("finished", 32'(done || lost), 1);
  endtask
  task automatic doAck();
    ack = 1'b1;
    @(posedge clk_tb);
    #1 ack = 1'b0;
    chk("ackInit", 32'(init), 1);
  endtask
  function automatic int countRev(input int loX, input int hiX);
    int n = 0;
    for (int i = 0; i < 64; i++) if (i % 8 >= loX && i % 8 <= hiX && rev[i] === 1'b1) n++;
    return n;
  endfunction
  initial begin
    reset = 1'b1; start = 1'b0; ack = 1'b0; clearRev = 1'b1;
    startX = '0; startY = '0;
    setMines(0);
    repeat (2) @(posedge clk_tb);
    #1 reset = 1'b0; clearRev = 1'b0;
    chk("rstInit", 32'(init), 1);
    chk("rstCount", 32'(revealedCount), 0);
    chk("rstHit", 32'(hitMine), 0);
    chk("rstWe", 32'(board.revWriteEn), 0);
    chk("rstRead", 32'({board.readX, board.readY}), 0);
    // 1: empty board floods fully
    runOp(3'd3, 3'd4, cycles);
    chk("s1Done", 32'(done), 1);
    chk("s1Count", 32'(revealedCount), 64);
    chk("s1Cycles", 32'(cycles), 579);
    chk("s1Hit", 32'(hitMine), 0);
    chk("s1Board", 32'(countRev(0, 7)), 64);
    chk("s1Writes", 32'(writes), 64);
    doAck();
    // 2: start on a mine
    setMines(1);
    clearBoard();
    runOp(3'd2, 3'd2, cycles);
    chk("s2Lost", 32'(lost), 1);
    chk("s2Hit", 32'(hitMine), 1);
    chk("s2Cycles", 32'(cycles), 2);
    chk("s2Writes", 32'(writes), 0);
    doAck();
    chk("s2HitHeld", 32'(hitMine), 1);
    // 3: single reveal of a numbered cell
    setMines(2);
    clearBoard();
    runOp(3'd1, 3'd1, cycles);
    chk("s3Done", 32'(done), 1);
    chk("s3Count", 32'(revealedCount), 1);
    chk("s3Hit", 32'(hitMine), 0);
    chk("s3Writes", 32'(writes), 1);
    chk("s3Where", 32'(lastWrite), 9);
    chk("s3Cycles", 32'(cycles), 2);
    doAck();
    // 5: same cell again, already revealed
    w0 = writes;
    runOp(3'd1, 3'd1, cycles);
    chk("s5Done", 32'(done), 1);
    chk("s5Count", 32'(revealedCount), 0);
    chk("s5Writes", 32'(writes - w0), 0);
    doAck();
    // 4: mine column at x=4 bounds the flood
    setMines(3);
    clearBoard();
    runOp(3'd0, 3'd0, cycles);
    chk("s4Done", 32'(done), 1);
    chk("s4Count", 32'(revealedCount), 32);
    chk("s4Left", 32'(countRev(0, 3)), 32);
    chk("s4Right", 32'(countRev(4, 7)), 0);
    chk("s4Cycles", 32'(cycles), 219);
    doAck();
    // 6: reset in the middle of a scan, then a clean rerun
    setMines(0);
    clearBoard();
    startX = 3'd3; startY = 3'd4; start = 1'b1;
    @(posedge clk_tb);
    #1 start = 1'b0;
    repeat (39) @(posedge clk_tb);
    #1 chk("s6Scan", 32'(scan), 1);
    reset = 1'b1;
    @(posedge clk_tb);
    #1 chk("s6Init", 32'(init), 1);
    chk("s6We", 32'(board.revWriteEn), 0);
    chk("s6Empty", 32'(dut.stack.empty), 1);
    chk("s6Read", 32'({board.readX, board.readY}), 0);
    reset = 1'b0;
    chk("s6Partial", 32'(writes > 0 && writes < 64), 1);
    clearBoard();
    runOp(3'd3, 3'd4, cycles);
    chk("s6Count", 32'(revealedCount), 64);
    chk("s6Cycles", 32'(cycles), 579);
    chk("s6Board", 32'(countRev(0, 7)), 64);
    doAck();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
